// File: rtl/switch_poll_pkg.sv
// Shared definitions for the switch polling controller: CSR map, control/status
// bit positions and the poll FSM state type.
package switch_poll_pkg;

  localparam logic [1:0] CSR_STATUS = 2'd0;
  localparam logic [1:0] CSR_CTRL   = 2'd1;
  localparam logic [1:0] CSR_COUNT  = 2'd2;
  localparam logic [1:0] CSR_ACK    = 2'd3;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  localparam int unsigned STAT_LEVEL   = 0;
  localparam int unsigned STAT_PENDING = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_POL     = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    SAMPLE
  } poll_state_t;

endpackage

// File: rtl/switch_poll_debounce.sv
// Debouncer: the level flips only after DEBOUNCE_N consecutive valid samples that
// differ from it; rise/fall are single-cycle pulses on the sample that flips it.
module switch_poll_debounce #(
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_vld,
  input  logic sample,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned RUN_W = 4;

  logic             level_q, level_d;
  logic [RUN_W-1:0] run_q, run_d;

  always_comb begin
    level_d = level_q;
    run_d   = run_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (sample_vld) begin
      if (sample == level_q) begin
        run_d = '0;
      end else if (run_q == RUN_W'(DEBOUNCE_N - 1)) begin
        level_d = ~level_q;
        run_d   = '0;
        rise    = ~level_q;
        fall    = level_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      run_q   <= '0;
    end else begin
      level_q <= level_d;
      run_q   <= run_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/switch_poll_ctrl.sv
// Avalon-MM switch poller: periodic PIO read, debounce, edge counting, IRQ and CSRs.
// Optional build macro: SWPOLL_FALL_EDGE_EN (falling transitions also count as events).
module switch_poll_ctrl
  import switch_poll_pkg::*;
#(
  parameter int unsigned POLL_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        irq
);

  localparam int unsigned DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  poll_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       lat_q, lat_d;
  logic             samp_q, samp_d;
  logic             drop_q, drop_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pending_q, pending_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             pol_q, pol_d;

  logic en, tick, sample_vld, level, rise, fall, ev;
  logic wr_ctrl, wr_count, wr_ack;
  logic [31:0] status;

  assign en   = ctrl_q[CTRL_EN];
  assign tick = en && (div_q == DIV_W'(POLL_DIV - 1));

  always_comb begin
    div_d = '0;
    if (en) div_d = tick ? '0 : div_q + 1'b1;
  end

  // An accepted read always runs to completion; clearing en only marks the sample
  // to be dropped, so the fabric never sees an abandoned request.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    samp_d     = samp_q;
    drop_d     = drop_q;
    sample_vld = 1'b0;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (tick) state_d = REQ;
      end
      REQ: begin
        if (!avm_waitrequest) begin
          state_d = WAIT;
          lat_d   = '0;
        end
      end
      WAIT: begin
        if (lat_q == 2'(RD_LATENCY - 1)) begin
          samp_d  = avm_readdata[0];
          state_d = SAMPLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      SAMPLE: begin
        sample_vld = !drop_q && en;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !en) drop_d = 1'b1;
  end

  switch_poll_debounce #(
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .sample_vld(sample_vld),
    .sample    (samp_q),
    .level     (level),
    .rise      (rise),
    .fall      (fall)
  );

`ifdef SWPOLL_FALL_EDGE_EN
  assign ev    = rise | fall;
  assign pol_d = ev ? rise : pol_q;
`else
  logic unused_fall;
  assign unused_fall = fall;
  assign ev          = rise;
  assign pol_d       = 1'b0;
`endif

  assign wr_ctrl  = avs_write && (avs_address == CSR_CTRL);
  assign wr_count = avs_write && (avs_address == CSR_COUNT);
  assign wr_ack   = avs_write && (avs_address == CSR_ACK);

  always_comb begin
    status               = '0;
    status[STAT_LEVEL]   = level;
    status[STAT_PENDING] = pending_q;
    status[STAT_BUSY]    = (state_q != IDLE);
    status[STAT_POL]     = pol_q;
  end

  // A new event wins over a same-cycle software clear of either pending or count.
  always_comb begin
    ctrl_d    = wr_ctrl ? avs_writedata[1:0] : ctrl_q;
    count_d   = count_q;
    pending_d = pending_q;
    if (wr_count)                   count_d = ev ? CNT_W'(1) : '0;
    else if (ev && count_q != '1)   count_d = count_q + 1'b1;
    if (ev)                         pending_d = 1'b1;
    else if (wr_ack && avs_writedata[0]) pending_d = 1'b0;
    irq_d   = pending_q & ctrl_q[CTRL_IE];
    rdata_d = '0;
    if (avs_read) begin
      case (avs_address)
        CSR_STATUS: rdata_d = status;
        CSR_CTRL:   rdata_d = {30'b0, ctrl_q};
        CSR_COUNT:  rdata_d = 32'(count_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      lat_q     <= '0;
      samp_q    <= 1'b0;
      drop_q    <= 1'b0;
      ctrl_q    <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      pol_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      lat_q     <= lat_d;
      samp_q    <= samp_d;
      drop_q    <= drop_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      pol_q     <= pol_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{avs_writedata[31:2], avm_readdata[31:1]};

  assign avm_address  = '0;
  assign avm_read     = (state_q == REQ);
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_switch_poll_ctrl.sv
// Self-checking bench for switch_poll_ctrl: Avalon slave responders, a sample-history
// debounce/event model, and scenario tasks. Honours SWPOLL_FALL_EDGE_EN if defined.
module tb_switch_poll_ctrl;
  import switch_poll_pkg::*;

  localparam int unsigned DEB_N   = 4;
  localparam int unsigned CNT_MAX = 16'hFFFF;
`ifdef SWPOLL_FALL_EDGE_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  avs_address, avs2_address;
  logic        avs_read, avs_write, avs2_read, avs2_write;
  logic [31:0] avs_writedata, avs2_writedata, avs_readdata, avs2_readdata;
  logic [1:0]  avm_address, avm2_address;
  logic        avm_read, avm2_read, avm_waitrequest, irq, irq2;
  logic [31:0] avm_readdata, avm2_readdata;

  always #5 clk = ~clk;

  switch_poll_ctrl #(.POLL_DIV(16), .DEBOUNCE_N(4), .RD_LATENCY(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .irq(irq));

  switch_poll_ctrl #(.POLL_DIV(8), .DEBOUNCE_N(1), .RD_LATENCY(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .avs_address(avs2_address), .avs_read(avs2_read),
    .avs_write(avs2_write), .avs_writedata(avs2_writedata), .avs_readdata(avs2_readdata),
    .avm_address(avm2_address), .avm_read(avm2_read), .avm_waitrequest(1'b0),
    .avm_readdata(avm2_readdata), .irq(irq2));

  int n_tests = 0;
  int n_fail  = 0;

  bit sw;
  bit delivered[$];
  int n_acc = 0;
  int n_acc2 = 0;
  bit s2;
  int rise_q[$];
  int cyc = 0;

  // Behavioural model: level flips once the latest DEB_N samples since the last flip
  // all disagree with it.
  bit m_level, m_pending, m_pol, m_ie;
  int unsigned m_count;
  bit m_hist[$];

  function automatic void m_reset();
    m_level = 0; m_pending = 0; m_pol = 0; m_ie = 0; m_count = 0;
    m_hist.delete();
  endfunction

  function automatic void m_sample(bit s);
    bit all_diff;
    bit rising;
    m_hist.push_back(s);
    if (m_hist.size() >= DEB_N) begin
      all_diff = 1;
      for (int i = int'(m_hist.size()) - int'(DEB_N); i < int'(m_hist.size()); i++)
        if (m_hist[i] == m_level) all_diff = 0;
      if (all_diff) begin
        rising  = !m_level;
        m_level = !m_level;
        m_hist.delete();
        if (rising || FALL_EN) begin
          m_count   = (m_count == CNT_MAX) ? CNT_MAX : m_count + 1;
          m_pending = 1;
          m_pol     = rising;
        end
      end
    end
  endfunction

  function automatic logic [31:0] m_status();
    return {28'b0, FALL_EN & m_pol, 1'b0, m_pending, m_level};
  endfunction

  // Slave for dut: readdata carries the switch bit only in the valid cycle.
  initial begin
    logic [31:0] r;
    bit v;
    avm_readdata = '0;
    forever begin
      @(negedge clk); #1;
      if (avm_read === 1'b1 && avm_waitrequest === 1'b0 && reset === 1'b0) begin
        v = sw;
        delivered.push_back(v);
        n_acc++;
        @(negedge clk);
        r = $urandom(); avm_readdata = {r[31:1], v};
        @(negedge clk);
        r = $urandom(); avm_readdata = {r[31:1], ~v};
      end
    end
  end

  // Slave for dut2 (latency 2): alternating switch values starting at 1.
  initial begin
    logic [31:0] r;
    bit v;
    avm2_readdata = '0;
    forever begin
      @(negedge clk); #1;
      if (avm2_read === 1'b1 && reset === 1'b0) begin
        v = s2; s2 = ~s2;
        n_acc2++;
        @(negedge clk);
        @(negedge clk);
        r = $urandom(); avm2_readdata = {r[31:1], v};
        @(negedge clk);
        r = $urandom(); avm2_readdata = {r[31:1], ~v};
      end
    end
  end

  initial begin
    bit prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (avm_read === 1'b1 && !prev) rise_q.push_back(cyc);
      prev = (avm_read === 1'b1);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "bench time limit");
  end

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; d = avs_readdata;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic wait_acc(input int target);
    int budget = 200;
    while (n_acc < target && budget > 0) begin @(negedge clk); budget--; end
    n_tests++;
    if (n_acc < target) begin
      n_fail++;
      $display("FAIL acc_timeout: accepts %0d, required %0d", n_acc, target);
    end
  endtask

  task automatic wait_read_high();
    int budget = 60;
    while (avm_read !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    n_tests++;
    if (avm_read !== 1'b1) begin
      n_fail++;
      $display("FAIL read_timeout: avm_read %b, required 1", avm_read);
    end
  endtask

  task automatic poll_n(input int n, input bit v);
    sw = v;
    for (int i = 0; i < n; i++) begin
      wait_acc(n_acc + 1);
      if (delivered.size() > 0) m_sample(delivered.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; avs_read = 0; avs_write = 0; avm_waitrequest = 0; sw = 0;
    avs2_read = 0; avs2_write = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    delivered.delete(); rise_q.delete(); m_reset();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int acc0;
    do_reset();
    n_tests++;
    if (avm_read !== 0 || irq !== 0 || avs_readdata !== 0 || avm_address !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: read %b irq %b rdata %h addr %h, required 0", avm_read, irq, avs_readdata, avm_address);
    end
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), rd);
      n_tests++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_csr%0d: got %h, required 0", a, rd); end
    end
    acc0 = n_acc;
    csr_write(CSR_STATUS, 32'hFFFF_FFFF);
    csr_write(CSR_CTRL, 32'hFFFF_FFFE);
    csr_read(CSR_CTRL, rd);
    n_tests++;
    if (rd !== 32'h2) begin n_fail++; $display("FAIL ctrl_readback: got %h, required 2", rd); end
    csr_write(CSR_CTRL, 32'h0);
    repeat (40) @(negedge clk);
    csr_read(CSR_STATUS, rd);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL status_idle: got %h, required 0", rd); end
    n_tests++;
    if (rise_q.size() != 0 || n_acc != acc0) begin
      n_fail++;
      $display("FAIL idle_no_read: rises %0d, required 0", rise_q.size());
    end
  endtask

  task automatic test_poll_rise();
    logic [31:0] rd;
    do_reset();
    csr_write(CSR_CTRL, 32'h1);
    poll_n(3, 1);
    repeat (4) @(negedge clk);
    csr_read(CSR_STATUS, rd);
    n_tests++;
    if (rd !== m_status()) begin n_fail++; $display("FAIL rise_3_samples: status %h, required %h", rd, m_status()); end
    poll_n(1, 1);
    repeat (4) @(negedge clk);
    csr_read(CSR_STATUS, rd);
    n_tests++;
    if (rd !== m_status()) begin n_fail++; $display("FAIL rise_status: status %h, required %h", rd, m_status()); end
    csr_read(CSR_COUNT, rd);
    n_tests++;
    if (rd !== 32'(m_count)) begin n_fail++; $display("FAIL rise_count: got %h, required %h", rd, m_count); end
    n_tests++;
    if (rise_q.size() < 4) begin
      n_fail++; $display("FAIL poll_period: rises %0d, required 4", rise_q.size());
    end else begin
      for (int i = 1; i < 4; i++)
        if (rise_q[i] - rise_q[i-1] != 16) begin
          n_fail++; $display("FAIL poll_period: gap %0d, required 16", rise_q[i] - rise_q[i-1]);
        end
    end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b, required 0", irq); end
    avs_address = CSR_CTRL; avs_writedata = 32'h3; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_latency: got %b, required 0", irq); end
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enable: got %b, required 1", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    do_reset();
    csr_write(CSR_CTRL, 32'h1);
    poll_n(3, 1);
    poll_n(1, 0);
    repeat (4) @(negedge clk);
    csr_read(CSR_STATUS, rd);
    n_tests++;
    if (rd !== m_status() || rd[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_level: status %h, required %h", rd, m_status()); end
    csr_read(CSR_COUNT, rd);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL glitch_count: got %h, required 0", rd); end
  endtask

  task automatic test_waitrequest();
    logic [31:0] rd;
    int acc0;
    do_reset();
    sw = 1; avm_waitrequest = 1'b1;
    acc0 = n_acc;
    csr_write(CSR_CTRL, 32'h1);
    wait_read_high();
    for (int i = 0; i < 20; i++) begin
      csr_read(CSR_STATUS, rd);
      n_tests++;
      if (avm_read !== 1'b1 || rd[STAT_BUSY] !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold: read %b busy %b, required 1 1", avm_read, rd[STAT_BUSY]);
      end
    end
    avm_waitrequest = 1'b0;
    poll_n(1, 1);
    repeat (4) @(negedge clk);
    n_tests++;
    if (n_acc != acc0 + 1 || rise_q.size() != 1) begin
      n_fail++; $display("FAIL stall_single: accepts %0d rises %0d, required 1 1", n_acc - acc0, rise_q.size());
    end
  endtask

  task automatic test_clear_race();
    logic [31:0] rd;
    int budget;
    do_reset();
    csr_write(CSR_CTRL, 32'h1);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        csr_write(CSR_ACK, 32'h1); m_pending = 0;
        poll_n(4, 0);
      end
      poll_n(3, 1);
      budget = 40;
      while (!(avm_read === 1'b1 && avm_waitrequest === 1'b0) && budget > 0) begin @(negedge clk); budget--; end
      @(negedge clk);
      @(negedge clk);
      avs_address = (pass == 0) ? CSR_ACK : CSR_COUNT; avs_writedata = 32'h1; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
      if (pass == 0) m_pending = 0; else m_count = 0;
      wait_acc(n_acc);
      if (delivered.size() > 0) m_sample(delivered.pop_front());
      repeat (2) @(negedge clk);
      csr_read(CSR_STATUS, rd);
      n_tests++;
      if (rd !== m_status()) begin n_fail++; $display("FAIL race_status%0d: status %h, required %h", pass, rd, m_status()); end
      csr_read(CSR_COUNT, rd);
      n_tests++;
      if (rd !== 32'(m_count)) begin n_fail++; $display("FAIL race_count%0d: got %h, required %h", pass, rd, m_count); end
    end
  endtask

  task automatic test_fall();
    logic [31:0] rd;
    do_reset();
    csr_write(CSR_CTRL, 32'h1);
    poll_n(4, 1);
    repeat (4) @(negedge clk);
    csr_read(CSR_STATUS, rd);
    n_tests++;
    if (rd !== m_status()) begin n_fail++; $display("FAIL fall_pre: status %h, required %h", rd, m_status()); end
    poll_n(4, 0);
    repeat (4) @(negedge clk);
    csr_read(CSR_STATUS, rd);
    n_tests++;
    if (rd !== m_status()) begin n_fail++; $display("FAIL fall_status: status %h, required %h", rd, m_status()); end
    csr_read(CSR_COUNT, rd);
    n_tests++;
    if (rd !== 32'(m_count)) begin n_fail++; $display("FAIL fall_count: got %h, required %h", rd, m_count); end
  endtask

  task automatic test_en_clear();
    logic [31:0] rd;
    int acc0, rises0;
    do_reset();
    csr_write(CSR_CTRL, 32'h1);
    poll_n(3, 1);
    avm_waitrequest = 1'b1;
    wait_read_high();
    csr_write(CSR_CTRL, 32'h0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (avm_read !== 1'b1) begin n_fail++; $display("FAIL en_clear_hold: read %b, required 1", avm_read); end
    acc0 = n_acc;
    avm_waitrequest = 1'b0;
    wait_acc(acc0 + 1);
    if (delivered.size() > 0) void'(delivered.pop_front());
    repeat (4) @(negedge clk);
    csr_read(CSR_STATUS, rd);
    n_tests++;
    if (rd !== m_status()) begin n_fail++; $display("FAIL en_clear_drop: status %h, required %h", rd, m_status()); end
    rises0 = rise_q.size();
    repeat (40) @(negedge clk);
    n_tests++;
    if (rise_q.size() != rises0) begin n_fail++; $display("FAIL en_clear_stop: rises %0d, required %0d", rise_q.size(), rises0); end
    csr_write(CSR_CTRL, 32'h1);
    poll_n(1, 1);
    repeat (4) @(negedge clk);
    csr_read(CSR_STATUS, rd);
    n_tests++;
    if (rd !== m_status()) begin n_fail++; $display("FAIL en_resume: status %h, required %h", rd, m_status()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    do_reset();
    csr_write(CSR_CTRL, 32'h1);
    avm_waitrequest = 1'b1;
    wait_read_high();
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (avm_read !== 1'b0) begin n_fail++; $display("FAIL reset_mid_read: got %b, required 0", avm_read); end
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    csr_read(CSR_STATUS, rd);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_mid_status: got %h, required 0", rd); end
    csr_read(CSR_CTRL, rd);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_mid_ctrl: got %h, required 0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    bit s = 0;
    int act;
    do_reset();
    csr_write(CSR_CTRL, 32'h3);
    m_ie = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) s = ~s;
      poll_n(1, s);
      repeat (4) @(negedge clk);
      act = $urandom_range(0, 7);
      if (act == 0) begin csr_write(CSR_ACK, 32'h1); m_pending = 0; end
      else if (act == 1) begin csr_write(CSR_COUNT, $urandom()); m_count = 0; end
      else if (act == 2) csr_write(CSR_ACK, 32'h2);
      csr_read(CSR_STATUS, rd);
      n_tests++;
      if (rd !== m_status()) begin n_fail++; $display("FAIL rand_status%0d: status %h, required %h", i, rd, m_status()); end
      csr_read(CSR_COUNT, rd);
      n_tests++;
      if (rd !== 32'(m_count)) begin n_fail++; $display("FAIL rand_count%0d: got %h, required %h", i, rd, m_count); end
      n_tests++;
      if (irq !== (m_pending & m_ie)) begin n_fail++; $display("FAIL rand_irq%0d: got %b, required %b", i, irq, m_pending & m_ie); end
    end
  endtask

  task automatic test_saturate();
    int budget, k, exp;
    do_reset();
    n_acc2 = 0; s2 = 1;
    avs2_address = CSR_CTRL; avs2_writedata = 32'h1; avs2_write = 1'b1;
    @(negedge clk);
    avs2_write = 1'b0;
    for (int stage = 0; stage < 2; stage++) begin
      budget = 200;
      while (n_acc2 < ((stage == 0) ? 2 : 10) && budget > 0) begin @(negedge clk); budget--; end
      repeat (5) @(negedge clk);
      k = n_acc2;
      exp = (k + 1) / 2 + (FALL_EN ? k / 2 : 0);
      if (exp > 3) exp = 3;
      avs2_address = CSR_COUNT; avs2_read = 1'b1;
      @(negedge clk);
      avs2_read = 1'b0;
      n_tests++;
      if (avs2_readdata !== 32'(exp) || k < ((stage == 0) ? 2 : 10)) begin
        n_fail++; $display("FAIL sat_count%0d: got %h after %0d samples, required %h", stage, avs2_readdata, k, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    avs2_address = '0; avs2_read = 0; avs2_write = 0; avs2_writedata = '0;
    avm_waitrequest = 0; sw = 0; s2 = 1;
    m_reset();
    @(negedge clk);
    test_reset();
    test_poll_rise();
    test_glitch();
    test_waitrequest();
    test_clear_race();
    test_fall();
    test_en_clear();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
